// File: rtl/memctrl_if.sv
// memctrl_if: groups the load/store unit, instruction-fetch and RAM-side
// signals of the memory controller. The slave modport is the controller
// itself. The master modport is the surrounding system, which drives the
// requests and returns RAM read data.
interface memctrl_if;
  // Load/store unit request and response.
  logic        ls_enable;
  logic [31:0] addr;
  logic [31:0] store_val;
  logic [3:0]  lsb_type;
  logic        ls_finished;
  logic [31:0] load_val;
  // Instruction fetch request and response.
  logic        if_enable;
  logic [31:0] if_addr;
  logic        if_finished;
  logic [31:0] if_inst;
  // Byte-wide RAM port and UART back-pressure.
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  ls_enable, addr, store_val, lsb_type, if_enable, if_addr, mem_din, io_buffer_full,
    output ls_finished, load_val, if_finished, if_inst, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ls_enable, addr, store_val, lsb_type, if_enable, if_addr, mem_din, io_buffer_full,
    input  ls_finished, load_val, if_finished, if_inst, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/memctrl.sv
// memctrl: serialises load/store and instruction-fetch requests onto a
// byte-wide RAM. Reads issue one address per cycle and assemble bytes as
// they come back two edges later. Writes issue one byte per cycle.
// Optional feature: define MEMCTRL_IO_STALL_EN to hold store bytes aimed at
// the IO window (addr[17:16] == 2'b11) while the UART buffer is full.
module memctrl (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear,
  memctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;       // READ: edges since accept; WRITE: next byte index
  logic [31:0] base_q, base_d;
  logic [2:0]  type_q, type_d;     // size/sign bits of the load type; fetch uses LW
  logic [31:0] data_q, data_d;     // store data, or read bytes assembled so far
  logic        is_ls_q, is_ls_d;   // requester: 1 = load/store unit, 0 = fetch

  logic        ls_fin_q, ls_fin_d;
  logic        if_fin_q, if_fin_d;
  logic [31:0] load_val_q, load_val_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;

  logic [2:0]  n_bytes;
  logic [31:0] cur_addr;
  logic [1:0]  rd_idx;
  logic        stall_accept, stall_wr;

  assign n_bytes  = (type_q[1:0] == 2'b00) ? 3'd1 : (type_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign cur_addr = base_q + 32'(cnt_q);
  // Byte captured at edge k was addressed at edge k-2.
  assign rd_idx   = cnt_q[1:0] - 2'd2;

`ifdef MEMCTRL_IO_STALL_EN
  assign stall_accept = (bus.addr[17:16] == 2'b11) && bus.io_buffer_full;
  assign stall_wr     = (cur_addr[17:16] == 2'b11) && bus.io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = bus.io_buffer_full;
  assign stall_accept   = 1'b0;
  assign stall_wr       = 1'b0;
`endif

  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [2:0] t);
    case (t)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    type_d     = type_q;
    data_d     = data_q;
    is_ls_d    = is_ls_q;
    ls_fin_d   = 1'b0;
    if_fin_d   = 1'b0;
    load_val_d = load_val_q;
    if_inst_d  = if_inst_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!clear && !ls_fin_q && !if_fin_q) begin
          if (bus.ls_enable) begin
            base_d  = bus.addr;
            type_d  = bus.lsb_type[2:0];
            is_ls_d = 1'b1;
            mem_a_d = bus.addr;
            if (bus.lsb_type[3]) begin
              state_d = WRITE;
              data_d  = bus.store_val;
              if (stall_accept) begin
                cnt_d = 3'd0;
              end else begin
                mem_wr_d   = 1'b1;
                mem_dout_d = bus.store_val[7:0];
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = READ;
              data_d  = '0;
              cnt_d   = 3'd1;
            end
          end else if (bus.if_enable) begin
            state_d = READ;
            base_d  = bus.if_addr;
            type_d  = 3'b010;
            is_ls_d = 1'b0;
            data_d  = '0;
            mem_a_d = bus.if_addr;
            cnt_d   = 3'd1;
          end
        end
      end

      READ: begin
        if (clear) begin
          state_d = IDLE;
        end else begin
          if (cnt_q < n_bytes) mem_a_d = cur_addr;
          if (cnt_q >= 3'd2) data_d[{rd_idx, 3'b000} +: 8] = bus.mem_din;
          if (cnt_q == n_bytes + 3'd1) begin
            state_d = DONE;
            if (is_ls_q) begin
              ls_fin_d   = 1'b1;
              load_val_d = extend_load(data_d, type_q);
            end else begin
              if_fin_d  = 1'b1;
              if_inst_d = data_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      // Stores always run to completion, even across a flush.
      WRITE: begin
        if (cnt_q == n_bytes) begin
          state_d  = DONE;
          ls_fin_d = 1'b1;
        end else if (!stall_wr) begin
          mem_a_d    = cur_addr;
          mem_dout_d = data_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and output registers: reset first, then freeze whenever rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      type_q     <= '0;
      data_q     <= '0;
      is_ls_q    <= 1'b0;
      ls_fin_q   <= 1'b0;
      if_fin_q   <= 1'b0;
      load_val_q <= '0;
      if_inst_q  <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      type_q     <= type_d;
      data_q     <= data_d;
      is_ls_q    <= is_ls_d;
      ls_fin_q   <= ls_fin_d;
      if_fin_q   <= if_fin_d;
      load_val_q <= load_val_d;
      if_inst_q  <= if_inst_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign bus.ls_finished = ls_fin_q;
  assign bus.if_finished = if_fin_q;
  assign bus.load_val    = load_val_q;
  assign bus.if_inst     = if_inst_q;
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = mem_dout_q;
  assign bus.mem_wr      = mem_wr_q;

endmodule
